// File: rtl/fifo_controller.sv
// fifo_controller
// Single-clock FIFO sequencer that treats an external dpram as circular storage.
// It owns the wrap-bit pointers, the occupancy count and the push/pop handshakes.
// Reads are show-ahead: the head word appears on out_data straight from the
// asynchronous RAM read port whenever the FIFO is not empty.
module fifo_controller #(
   parameter int ADDR_WIDTH         = 8,
   parameter int DATA_WIDTH         = 8,
   parameter int ALMOST_FULL_LEVEL  = 252,
   parameter int ALMOST_EMPTY_LEVEL = 4
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  flush,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ADDR_WIDTH:0]   level,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH-1:0] ram_write_address,
   output logic [DATA_WIDTH-1:0] ram_write_data,
   output logic                  ram_write,
   output logic [ADDR_WIDTH-1:0] ram_read_address,
   input  logic [DATA_WIDTH-1:0] ram_read_data
);

   localparam int PTR_WIDTH = ADDR_WIDTH + 1;

   localparam logic [PTR_WIDTH-1:0] PTR_ZERO = {PTR_WIDTH{1'b0}};
   localparam logic [PTR_WIDTH-1:0] PTR_ONE  = {{(PTR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [PTR_WIDTH-1:0] AF_LEVEL = PTR_WIDTH'(ALMOST_FULL_LEVEL);
   localparam logic [PTR_WIDTH-1:0] AE_LEVEL = PTR_WIDTH'(ALMOST_EMPTY_LEVEL);

   // Pointer advance; the carry into the MSB is the wrap bit.
   function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] ptr);
      return ptr + PTR_ONE;
   endfunction

   // Full when the RAM addresses match but the wrap bits differ.
   function automatic logic ptr_full(input logic [PTR_WIDTH-1:0] wp,
                                     input logic [PTR_WIDTH-1:0] rp);
      return (wp[ADDR_WIDTH-1:0] == rp[ADDR_WIDTH-1:0]) &&
             (wp[ADDR_WIDTH] != rp[ADDR_WIDTH]);
   endfunction

   logic [PTR_WIDTH-1:0] wr_ptr_r;
   logic [PTR_WIDTH-1:0] rd_ptr_r;
   logic [PTR_WIDTH-1:0] level_r;
   logic [PTR_WIDTH-1:0] wr_ptr_nxt_s;
   logic [PTR_WIDTH-1:0] rd_ptr_nxt_s;
   logic [PTR_WIDTH-1:0] level_nxt_s;
   logic                 empty_s;
   logic                 full_s;
   logic                 in_ready_s;
   logic                 out_valid_s;
   logic                 push_s;
   logic                 pop_s;

   assign empty_s     = (wr_ptr_r == rd_ptr_r);
   assign full_s      = ptr_full(wr_ptr_r, rd_ptr_r);

   // Flush and reset both mask pushes so no RAM write leaks out in a clearing cycle.
   assign in_ready_s  = !full_s && !flush && reset_n;
   assign out_valid_s = !empty_s;
   assign push_s      = in_valid && in_ready_s;
   assign pop_s       = out_valid_s && out_ready;

   assign in_ready          = in_ready_s;
   assign out_valid         = out_valid_s;
   assign out_data          = ram_read_data;
   assign ram_read_address  = rd_ptr_r[ADDR_WIDTH-1:0];
   assign ram_write         = push_s;
   assign ram_write_address = wr_ptr_r[ADDR_WIDTH-1:0];
   assign ram_write_data    = in_data;
   assign level             = level_r;
   assign almost_full       = (level_r >= AF_LEVEL);
   assign almost_empty      = (level_r <= AE_LEVEL);

   // Next pointer and occupancy values; flush wins over any push or pop.
   always_comb begin
      wr_ptr_nxt_s = wr_ptr_r;
      rd_ptr_nxt_s = rd_ptr_r;
      level_nxt_s  = level_r;
      if (flush) begin
         wr_ptr_nxt_s = PTR_ZERO;
         rd_ptr_nxt_s = PTR_ZERO;
         level_nxt_s  = PTR_ZERO;
      end else begin
         if (push_s) begin
            wr_ptr_nxt_s = ptr_inc(wr_ptr_r);
         end else begin
            wr_ptr_nxt_s = wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_nxt_s = ptr_inc(rd_ptr_r);
         end else begin
            rd_ptr_nxt_s = rd_ptr_r;
         end
         case ({push_s, pop_s})
            2'b10:   level_nxt_s = level_r + PTR_ONE;
            2'b01:   level_nxt_s = level_r - PTR_ONE;
            default: level_nxt_s = level_r;
         endcase
      end
   end

   // Pointer and occupancy registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         wr_ptr_r <= PTR_ZERO;
         rd_ptr_r <= PTR_ZERO;
         level_r  <= PTR_ZERO;
      end else begin
         wr_ptr_r <= wr_ptr_nxt_s;
         rd_ptr_r <= rd_ptr_nxt_s;
         level_r  <= level_nxt_s;
      end
   end

endmodule
